vec_sequencer: RTL and testbench

//  Multi-cycle controller sequencing the vector register file and ALU of the single-cycle core.
//  On a decoded vector instruction it stalls the PC and walks lanes 0..N-1.

---
 rtl/vec_pkg.sv | 45 ++++
 rtl/vec_lane_ctr.sv | 37 +++
 rtl/vec_sequencer.sv | 138 +++++++++++++
 tb/tb_vec_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types and constants for the vector sequencer.
//   LANES_DEF / IDXW_DEF : default lane count and lane index width
//   FLG_*               : NZCV bit positions within a 4-bit flag word
//   vec_state_e         : sequencer FSM states
//   vec_instr_t         : instruction fields latched at accept
//   eff_len()           : effective lane count from the requested length
package vec_pkg;

    localparam int unsigned LANES_DEF = 5;
    localparam int unsigned IDXW_DEF  = 3;

    localparam int unsigned OPW   = 3;
    localparam int unsigned ADDRW = 4;
    localparam int unsigned FLGW  = 4;

    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    // Accumulator seed: Z starts true so it can be AND-reduced across lanes.
    localparam logic [FLGW-1:0] FLAGS_INIT = 4'b0100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } vec_state_e;

    typedef struct packed {
        logic [OPW-1:0]   op;
        logic [ADDRW-1:0] src;
        logic [ADDRW-1:0] dst;
    } vec_instr_t;

    // Zero or an over-long request means "all lanes".
    function automatic int unsigned eff_len(input int unsigned vec_len, input int unsigned lanes);
        if (vec_len == 0 || vec_len > lanes) begin
            return lanes;
        end
        return vec_len;
    endfunction

endpackage

// File: rtl/vec_lane_ctr.sv
// Lane index counter for the vector sequencer.
//   clk, reset (sync, active-low)
//   load  : clear index to 0 and capture the last-lane value
//   last  : index of the final lane (L-1), captured on load
//   en    : advance to the next lane; saturates at the last lane
//   idx   : current lane index (registered)
//   tc_c  : terminal count, idx == last (decoded from registers)
module vec_lane_ctr #(
    parameter int unsigned IDXW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [IDXW-1:0] last,
    input  logic            en,
    output logic [IDXW-1:0] idx,
    output logic            tc_c
);

    logic [IDXW-1:0] last_q;

    // Index register; never steps past the captured last lane.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx    <= '0;
            last_q <= '0;
        end else if (load) begin
            idx    <= '0;
            last_q <= last;
        end else if (en && !tc_c) begin
            idx <= idx + IDXW'(1);
        end
    end

    assign tc_c = (idx == last_q);

endmodule

// File: rtl/vec_sequencer.sv
// Multi-cycle vector sequencer: stalls the core and walks lanes 0..L-1,
// giving each lane an EXEC cycle (operand read + ALU) and a WB cycle (write),
// then aggregates per-lane NZCV into one result.
//   clk, reset (sync, active-low)
//   start, VecOp, VecSrc, VecDst, VecLen : vector instruction from decoder
//   LaneFlags                             : NZCV of the ALU for the current lane
//   Stall  : hold PC / scalar writes (combinational, covers the start cycle)
//   Busy, Done, LaneIdx, VecWrite         : sequence status and lane control
//   VecRA, VecWA, VecALUControl           : latched instruction fields
//   VecFlags : aggregated NZCV, updated when Done rises, held afterwards
module vec_sequencer
    import vec_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned IDXW  = IDXW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OPW-1:0]   VecOp,
    input  logic [ADDRW-1:0] VecSrc,
    input  logic [ADDRW-1:0] VecDst,
    input  logic [IDXW-1:0]  VecLen,
    input  logic [FLGW-1:0]  LaneFlags,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic [IDXW-1:0]  LaneIdx,
    output logic [ADDRW-1:0] VecRA,
    output logic [ADDRW-1:0] VecWA,
    output logic [OPW-1:0]   VecALUControl,
    output logic             VecWrite,
    output logic [FLGW-1:0]  VecFlags
);

    vec_state_e      state, state_n;
    vec_instr_t      instr;
    logic [FLGW-1:0] acc, acc_n;
    logic            busy_n, done_n, write_n;
    logic            accept;
    logic            lane_en;
    logic            lane_tc;
    logic            flags_load;
    logic [IDXW-1:0] last_lane;

    // Final lane index is fixed at accept; later VecLen changes are ignored.
    assign last_lane = IDXW'(eff_len(32'(VecLen), LANES) - 1);

    vec_lane_ctr #(
        .IDXW (IDXW)
    ) u_lane_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .last  (last_lane),
        .en    (lane_en),
        .idx   (LaneIdx),
        .tc_c  (lane_tc)
    );

    // Next state, stall and lane control; status outputs derive from next state.
    always_comb begin
        state_n    = state;
        Stall      = 1'b0;
        accept     = 1'b0;
        lane_en    = 1'b0;
        flags_load = 1'b0;
        acc_n      = acc;
        case (state)
            S_IDLE: begin
                Stall = start;
                if (start) begin
                    accept  = 1'b1;
                    acc_n   = FLAGS_INIT;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                Stall        = 1'b1;
                acc_n[FLG_N] = LaneFlags[FLG_N];
                acc_n[FLG_Z] = acc[FLG_Z] & LaneFlags[FLG_Z];
                acc_n[FLG_C] = acc[FLG_C] | LaneFlags[FLG_C];
                acc_n[FLG_V] = acc[FLG_V] | LaneFlags[FLG_V];
                state_n      = S_WB;
            end
            S_WB: begin
                Stall = 1'b1;
                if (lane_tc) begin
                    flags_load = 1'b1;
                    state_n    = S_DONE;
                end else begin
                    lane_en = 1'b1;
                    state_n = S_EXEC;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        busy_n  = (state_n != S_IDLE);
        done_n  = (state_n == S_DONE);
        write_n = (state_n == S_WB);
    end

    // State, registered status, latched instruction and flag accumulation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            VecWrite <= 1'b0;
            instr    <= '0;
            acc      <= '0;
            VecFlags <= '0;
        end else begin
            state    <= state_n;
            Busy     <= busy_n;
            Done     <= done_n;
            VecWrite <= write_n;
            acc      <= acc_n;
            if (accept) begin
                instr <= '{op: VecOp, src: VecSrc, dst: VecDst};
            end
            // Accumulator already holds the last lane when its WB ends.
            if (flags_load) begin
                VecFlags <= acc;
            end
        end
    end

    assign VecRA         = instr.src;
    assign VecWA         = instr.dst;
    assign VecALUControl = instr.op;

endmodule

// File: tb/tb_vec_sequencer.sv
// Self-checking bench for vec_sequencer: directed scenarios plus randomized
// sequences checked against a cycle-level reference computed from lane count.
module tb_vec_sequencer;

    localparam int unsigned LANES = 5;
    localparam int unsigned IDXW  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [2:0]      VecOp;
    logic [3:0]      VecSrc;
    logic [3:0]      VecDst;
    logic [IDXW-1:0] VecLen;
    logic [3:0]      LaneFlags;
    logic            Stall;
    logic            Busy;
    logic            Done;
    logic [IDXW-1:0] LaneIdx;
    logic [3:0]      VecRA;
    logic [3:0]      VecWA;
    logic [2:0]      VecALUControl;
    logic            VecWrite;
    logic [3:0]      VecFlags;

    int checks = 0;
    int errors = 0;

    logic [3:0] lane_flags [LANES];
    logic [3:0] exp_vecflags;

    always #5 clk = ~clk;

    vec_sequencer #(
        .LANES (LANES),
        .IDXW  (IDXW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .VecOp         (VecOp),
        .VecSrc        (VecSrc),
        .VecDst        (VecDst),
        .VecLen        (VecLen),
        .LaneFlags     (LaneFlags),
        .Stall         (Stall),
        .Busy          (Busy),
        .Done          (Done),
        .LaneIdx       (LaneIdx),
        .VecRA         (VecRA),
        .VecWA         (VecWA),
        .VecALUControl (VecALUControl),
        .VecWrite      (VecWrite),
        .VecFlags      (VecFlags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full sequence accepted in the current IDLE cycle (cycle 0).
    // Lane k: EXEC at cycle 2k+1, WB at 2k+2; Done at 2L+1; IDLE at 2L+2.
    // s1/s2 are cycles where a stray start (with junk fields) is pulsed.
    task automatic run_vec(input logic [2:0] op, input logic [3:0] src, input logic [3:0] dst,
                           input logic [IDXW-1:0] len, input int s1, input int s2);
        int         n_lanes;
        int         writes;
        logic [3:0] ef;
        logic       e_busy, e_done, e_wr, e_stall;
        int         e_lane;

        n_lanes = (len == 0 || int'(len) > int'(LANES)) ? int'(LANES) : int'(len);
        ef = {lane_flags[n_lanes-1][3], 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < n_lanes; i++) begin
            ef[2] = ef[2] & lane_flags[i][2];
            ef[1] = ef[1] | lane_flags[i][1];
            ef[0] = ef[0] | lane_flags[i][0];
        end
        writes = 0;

        start     = 1'b1;
        VecOp     = op;
        VecSrc    = src;
        VecDst    = dst;
        VecLen    = len;
        LaneFlags = 4'($urandom);
        #1;
        check("stall_on_start", 32'(Stall), 32'(1));

        for (int c = 1; c <= 2 * n_lanes + 2; c++) begin
            @(posedge clk);
            #1;
            if (c <= 2 * n_lanes) begin
                e_busy = 1'b1; e_done = 1'b0; e_wr = (c % 2 == 0); e_lane = (c - 1) / 2;
            end else if (c == 2 * n_lanes + 1) begin
                e_busy = 1'b1; e_done = 1'b1; e_wr = 1'b0; e_lane = n_lanes - 1;
                exp_vecflags = ef;
            end else begin
                e_busy = 1'b0; e_done = 1'b0; e_wr = 1'b0; e_lane = n_lanes - 1;
            end
            if (VecWrite === 1'b1) writes++;
            check($sformatf("busy c%0d", c), 32'(Busy), 32'(e_busy));
            check($sformatf("done c%0d", c), 32'(Done), 32'(e_done));
            check($sformatf("vecwrite c%0d", c), 32'(VecWrite), 32'(e_wr));
            check($sformatf("laneidx c%0d", c), 32'(LaneIdx), 32'(e_lane));
            check($sformatf("vecra c%0d", c), 32'(VecRA), 32'(src));
            check($sformatf("vecwa c%0d", c), 32'(VecWA), 32'(dst));
            check($sformatf("aluctl c%0d", c), 32'(VecALUControl), 32'(op));
            check($sformatf("vecflags c%0d", c), 32'(VecFlags), 32'(exp_vecflags));

            if (c == s1 || c == s2) begin
                start  = 1'b1;
                VecOp  = 3'($urandom);
                VecSrc = 4'($urandom);
                VecDst = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            VecLen = IDXW'($urandom);
            if (c <= 2 * n_lanes && (c % 2) == 1) LaneFlags = lane_flags[(c - 1) / 2];
            else LaneFlags = 4'($urandom);
            e_stall = (c <= 2 * n_lanes);
            #1;
            check($sformatf("stall c%0d", c), 32'(Stall), 32'(e_stall));
        end
        check("write_count", 32'(writes), 32'(n_lanes));
    endtask

    task automatic rand_flags();
        for (int i = 0; i < int'(LANES); i++) lane_flags[i] = 4'($urandom);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_vecflags = 4'h0;
        reset     = 1'b0;
        start     = 1'b0;
        VecOp     = 3'h0;
        VecSrc    = 4'h0;
        VecDst    = 4'h0;
        VecLen    = '0;
        LaneFlags = 4'h0;

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(Busy), 32'(0));
        check("rst_done", 32'(Done), 32'(0));
        check("rst_write", 32'(VecWrite), 32'(0));
        check("rst_stall", 32'(Stall), 32'(0));
        check("rst_flags", 32'(VecFlags), 32'(0));
        check("rst_lane", 32'(LaneIdx), 32'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Full vector, VecLen=0 means all lanes.
        rand_flags();
        run_vec(3'b000, 4'h1, 4'h2, 3'd0, -1, -1);

        // Short vector, back-to-back with the previous one.
        rand_flags();
        run_vec(3'b010, 4'h3, 4'h7, 3'd2, -1, -1);

        // Directed flag aggregation.
        lane_flags[0] = 4'b0100;
        lane_flags[1] = 4'b0100;
        lane_flags[2] = 4'b0100;
        lane_flags[3] = 4'b0110;
        lane_flags[4] = 4'b1100;
        run_vec(3'b001, 4'h5, 4'h6, 3'd5, -1, -1);
        check("flags_directed", 32'(VecFlags), 32'(4'b1110));

        // Reset held two cycles during WB of lane 2.
        rand_flags();
        start = 1'b1; VecOp = 3'b011; VecSrc = 4'h9; VecDst = 4'hA; VecLen = 3'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_write", 32'(VecWrite), 32'(1));
        check("pre_rst_lane", 32'(LaneIdx), 32'(2));
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("mid_rst_write%0d", k), 32'(VecWrite), 32'(0));
            check($sformatf("mid_rst_stall%0d", k), 32'(Stall), 32'(0));
            check($sformatf("mid_rst_busy%0d", k), 32'(Busy), 32'(0));
            check($sformatf("mid_rst_flags%0d", k), 32'(VecFlags), 32'(0));
            check($sformatf("mid_rst_wa%0d", k), 32'(VecWA), 32'(0));
        end
        reset = 1'b1;
        exp_vecflags = 4'h0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("post_rst_write", 32'(VecWrite), 32'(0));
            check("post_rst_busy", 32'(Busy), 32'(0));
            check("post_rst_stall", 32'(Stall), 32'(0));
        end

        // Starts during EXEC and during DONE are ignored.
        rand_flags();
        run_vec(3'b100, 4'h4, 4'hB, 3'd5, 3, 11);

        // Over-long length clamps to all lanes.
        rand_flags();
        run_vec(3'b101, 4'hC, 4'hD, 3'd7, -1, -1);

        // Randomized sequences.
        for (int t = 0; t < 10; t++) begin
            rand_flags();
            run_vec(3'($urandom), 4'($urandom), 4'($urandom), IDXW'($urandom),
                    int'($urandom_range(1, 3)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
